// File: rtl/egg_miner.sv
// egg_miner: LANES lock-step mock-hash pipelines sweeping a nonce range against a target.
// One batch per ROUNDS+1 cycles; done pulses on win, exhaustion or abort; start is ignored while busy.
module egg_miner #(
  parameter int HDR_W   = 512,
  parameter int HASH_W  = 256,
  parameter int ROUNDS  = 64,
  parameter int LANES   = 4,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [HDR_W-1:0]   header,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_count,
  input  logic [HASH_W-1:0]  target,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0]  gold_hash,
  output logic [NONCE_W-1:0] hashes_done
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int CW = NONCE_W + 32;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_CHECK} state_t;

  state_t             state_q;
  logic [RW-1:0]      round_q;
  logic [HASH_W-1:0]  hhi_q, hlo_q, target_q;
  logic [NONCE_W-1:0] base_q, remaining_q;
  logic [HASH_W-1:0]  lane_q [LANES];
  logic               busy_q, done_q, found_q;
  logic [NONCE_W-1:0] found_nonce_q, hashes_done_q;
  logic [HASH_W-1:0]  gold_hash_q;

  logic [HASH_W-1:0]  lane_rnd_d [LANES];
  logic [LANES-1:0]   lane_ok_d;
  logic               win_d;
  logic [NONCE_W-1:0] win_nonce_d, valid_d, next_base_d;
  logic [HASH_W-1:0]  win_hash_d;

  function automatic logic [HASH_W-1:0] lane_init(input logic [HASH_W-1:0] lo,
                                                  input logic [NONCE_W-1:0] n);
    return lo ^ HASH_W'(n);
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_rnd_d[g] = ({lane_q[g][HASH_W-2:0], lane_q[g][HASH_W-1]} ^ hhi_q)
                           + HASH_W'(round_q);
  end

  // Scan from the top lane down so the lowest winning lane is the one left standing.
  always_comb begin
    lane_ok_d   = '0;
    win_d       = 1'b0;
    win_nonce_d = '0;
    win_hash_d  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      lane_ok_d[i] = CW'(remaining_q) > CW'(i);
      if (lane_ok_d[i] && (lane_q[i] < target_q)) begin
        win_d       = 1'b1;
        win_nonce_d = base_q + NONCE_W'(i);
        win_hash_d  = lane_q[i];
      end
    end
    valid_d     = (CW'(remaining_q) < CW'(LANES)) ? remaining_q : NONCE_W'(LANES);
    next_base_d = base_q + NONCE_W'(LANES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      hhi_q         <= '0;
      hlo_q         <= '0;
      target_q      <= '0;
      base_q        <= '0;
      remaining_q   <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      gold_hash_q   <= '0;
      hashes_done_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hhi_q         <= header[HDR_W-1 -: HASH_W];
            hlo_q         <= header[HASH_W-1:0];
            target_q      <= target;
            base_q        <= nonce_base;
            remaining_q   <= nonce_count;
            for (int i = 0; i < LANES; i++)
              lane_q[i] <= lane_init(header[HASH_W-1:0], nonce_base + NONCE_W'(i));
            round_q       <= '0;
            busy_q        <= 1'b1;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            gold_hash_q   <= '0;
            hashes_done_q <= '0;
            // An empty job still passes through CHECK so done lands one edge later.
            state_q       <= (nonce_count == '0) ? S_CHECK : S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            for (int i = 0; i < LANES; i++) lane_q[i] <= lane_rnd_d[i];
            if (round_q == RW'(ROUNDS - 1)) begin
              round_q <= '0;
              state_q <= S_CHECK;
            end else begin
              round_q <= round_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            hashes_done_q <= hashes_done_q + valid_d;
            remaining_q   <= remaining_q - valid_d;
            if (win_d || (remaining_q == valid_d)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (win_d) begin
                found_q       <= 1'b1;
                found_nonce_q <= win_nonce_d;
                gold_hash_q   <= win_hash_d;
              end
            end else begin
              base_q <= next_base_d;
              for (int i = 0; i < LANES; i++)
                lane_q[i] <= lane_init(hlo_q, next_base_d + NONCE_W'(i));
              state_q <= S_ROUND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign gold_hash   = gold_hash_q;
  assign hashes_done = hashes_done_q;
endmodule

// File: tb/tb_egg_miner.sv
// Bench for egg_miner: a small-parameter instance for hand-derived vectors and a default instance
// checked against a sequential reference model over random jobs.
`timescale 1ns/1ps
module tb_egg_miner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit           sel = 1'b0;
  logic         start_r = 1'b0, abort_r = 1'b0;
  logic [511:0] hdr_r = '0;
  logic [31:0]  base_r = '0, cnt_r = '0;
  logic [255:0] tgt_r = '0;

  logic         s_busy, s_done, s_found;
  logic [7:0]   s_fn, s_gh, s_hd;
  logic         d_busy, d_done, d_found;
  logic [31:0]  d_fn, d_hd;
  logic [255:0] d_gh;

  egg_miner #(.HDR_W(16), .HASH_W(8), .ROUNDS(2), .LANES(2), .NONCE_W(8)) dut_s (
    .clk(clk), .rst(rst), .start(start_r && !sel), .abort(abort_r && !sel),
    .header(hdr_r[15:0]), .nonce_base(base_r[7:0]), .nonce_count(cnt_r[7:0]),
    .target(tgt_r[7:0]), .busy(s_busy), .done(s_done), .found(s_found),
    .found_nonce(s_fn), .gold_hash(s_gh), .hashes_done(s_hd));

  egg_miner dut_d (
    .clk(clk), .rst(rst), .start(start_r && sel), .abort(abort_r && sel),
    .header(hdr_r), .nonce_base(base_r), .nonce_count(cnt_r), .target(tgt_r),
    .busy(d_busy), .done(d_done), .found(d_found), .found_nonce(d_fn),
    .gold_hash(d_gh), .hashes_done(d_hd));

  wire         o_busy  = sel ? d_busy  : s_busy;
  wire         o_done  = sel ? d_done  : s_done;
  wire         o_found = sel ? d_found : s_found;
  wire [31:0]  o_fn    = sel ? d_fn    : {24'b0, s_fn};
  wire [31:0]  o_hd    = sel ? d_hd    : {24'b0, s_hd};
  wire [255:0] o_gh    = sel ? d_gh    : {248'b0, s_gh};

  typedef struct packed {
    bit         found;
    bit [31:0]  fn;
    bit [31:0]  hd;
    bit [255:0] gh;
    int         lat;
  } exp_t;

  typedef struct {
    bit [15:0] hdr;
    bit [7:0]  b, c, t;
    exp_t      e;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(bit f, bit [31:0] fn, bit [31:0] hd, bit [255:0] gh, int lat);
    exp_t e;
    e.found = f; e.fn = fn; e.hd = hd; e.gh = gh; e.lat = lat;
    return e;
  endfunction

  // Sequential reference: walk nonces one at a time, then derive batch-granular counts and timing.
  function automatic exp_t model(bit big, bit [511:0] h, bit [31:0] b, bit [31:0] c, bit [255:0] t);
    exp_t e;
    int hw, nw, ln, rn, hdw, kw, nb, cn;
    bit [255:0] hm, hhi, hlo, s, tg;
    bit [31:0] nm, nonce;
    bit [511:0] tmp;
    hw = big ? 256 : 8;  nw = big ? 32 : 8;  ln = big ? 4 : 2;
    rn = big ? 64 : 2;   hdw = big ? 512 : 16;
    hm  = {256{1'b1}} >> (256 - hw);
    nm  = 32'hFFFF_FFFF >> (32 - nw);
    tmp = h >> (hdw - hw);
    hhi = tmp[255:0] & hm;
    hlo = h[255:0] & hm;
    tg  = t & hm;
    cn  = int'(c & nm);
    e = '0;
    kw = -1;
    for (int k = 0; k < cn && kw < 0; k++) begin
      nonce = (b + 32'(k)) & nm;
      s = hlo ^ {224'b0, nonce};
      for (int r = 0; r < rn; r++) begin
        s = (((s << 1) | (s >> (hw - 1))) & hm) ^ hhi;
        s = (s + 256'(r)) & hm;
      end
      if (s < tg) begin
        kw = k; e.found = 1'b1; e.fn = nonce; e.gh = s;
      end
    end
    nb = (kw >= 0) ? kw / ln + 1 : (cn + ln - 1) / ln;
    e.hd  = 32'((nb * ln < cn) ? nb * ln : cn);
    e.lat = (nb == 0) ? 1 : nb * (rn + 1);
    return e;
  endfunction

  task automatic run_job(input bit big, input bit [511:0] h, input bit [31:0] b, input bit [31:0] c,
                         input bit [255:0] t, input exp_t e_in, input int abort_at,
                         input bit glitch, input string tag);
    exp_t e;
    int   n;
    bit   seen, busy_ok;
    @(negedge clk);
    sel = big; hdr_r = h; base_r = b; cnt_r = c; tgt_r = t; start_r = 1'b1;
    exp_q.push_back(e_in);
    @(posedge clk); #1;
    start_r = 1'b0;
    chk({tag, ".busy_e0"}, o_busy, 1'b1);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 2000) begin
      if (abort_at != 0 && n == abort_at) abort_r = 1'b1;
      if (glitch && n == 1) begin
        start_r = 1'b1; base_r = ~b; cnt_r = 32'd2; tgt_r = '1;
      end
      @(posedge clk); #1;
      n++;
      abort_r = 1'b0;
      start_r = 1'b0;
      seen = o_done;
      if (!seen && !o_busy) busy_ok = 1'b0;
    end
    e = exp_q.pop_front();
    chk({tag, ".done_seen"}, seen, 1'b1);
    chk({tag, ".latency"}, n, e.lat);
    chk({tag, ".busy_held"}, busy_ok, 1'b1);
    chk({tag, ".busy_done"}, o_busy, 1'b0);
    chk({tag, ".found"}, o_found, e.found);
    chk({tag, ".found_nonce"}, o_fn, e.fn);
    chk({tag, ".gold_hash"}, o_gh, e.gh);
    chk({tag, ".hashes_done"}, o_hd, e.hd);
  endtask

  vec_t         tbl[8];
  bit [511:0]   rh;
  bit [255:0]   rt;
  bit [31:0]    rb, rc;
  bit           saw;

  initial begin
    // Lane hashes for header A53C, nonces 0..4: 1F 1B 17 13 0F; nonce FF: E2.
    tbl[0] = '{16'hA53C, 8'h00, 8'd2, 8'h1C, mk(1, 32'h01, 2, 256'h1B, 3)};
    tbl[1] = '{16'hA53C, 8'h00, 8'd2, 8'h20, mk(1, 32'h00, 2, 256'h1F, 3)};
    tbl[2] = '{16'hA53C, 8'h00, 8'd5, 8'h0F, mk(0, 32'h00, 5, 256'h00, 9)};
    tbl[3] = '{16'hA53C, 8'h00, 8'd5, 8'h10, mk(1, 32'h04, 5, 256'h0F, 9)};
    tbl[4] = '{16'hA53C, 8'h00, 8'd0, 8'hFF, mk(0, 32'h00, 0, 256'h00, 1)};
    tbl[5] = '{16'hA53C, 8'hFF, 8'd2, 8'h20, mk(1, 32'h00, 2, 256'h1F, 3)};
    tbl[6] = '{16'hA53C, 8'hFF, 8'd2, 8'hFF, mk(1, 32'hFF, 2, 256'hE2, 3)};
    tbl[7] = '{16'hA53C, 8'h00, 8'd3, 8'h18, mk(1, 32'h02, 3, 256'h17, 6)};

    #12;
    chk("rst.s_busy", s_busy, 1'b0);
    chk("rst.s_done", s_done, 1'b0);
    chk("rst.s_found", s_found, 1'b0);
    chk("rst.s_outputs", {s_fn, s_gh, s_hd}, 24'h0);
    chk("rst.d_busy", d_busy, 1'b0);
    chk("rst.d_outputs", {d_done, d_found, d_fn, d_hd}, 66'h0);
    chk("rst.d_gold", d_gh, 256'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      run_job(0, {496'b0, tbl[i].hdr}, {24'b0, tbl[i].b}, {24'b0, tbl[i].c}, {248'b0, tbl[i].t},
              tbl[i].e, 0, 0, $sformatf("vec%0d", i));

    run_job(0, 512'hA53C, 32'hFE, 32'd4, 256'h14, model(0, 512'hA53C, 32'hFE, 32'd4, 256'h14), 0, 0, "wrap_model_a");
    run_job(0, 512'hA53C, 32'hFF, 32'd2, 256'h20, model(0, 512'hA53C, 32'hFF, 32'd2, 256'h20), 0, 0, "wrap_model_b");

    run_job(0, 512'hA53C, 32'h00, 32'd5, 256'h10, tbl[3].e, 0, 1, "start_busy");
    @(posedge clk); #1;
    chk("start_busy.no_reaccept", o_busy, 1'b0);

    // Abort lands on the first CHECK edge, where lane 0 would otherwise win.
    run_job(0, 512'hA53C, 32'h00, 32'd200, 256'hFF, mk(0, 0, 0, 0, 3), 2, 0, "abort_vs_win");
    run_job(0, 512'hA53C, 32'h00, 32'd200, 256'h00, mk(0, 0, 2, 0, 6), 5, 0, "abort_mid");

    @(negedge clk);
    sel = 1'b0; abort_r = 1'b1;
    @(posedge clk); #1;
    abort_r = 1'b0;
    chk("abort_idle.done", o_done, 1'b0);
    chk("abort_idle.busy", o_busy, 1'b0);

    run_job(0, 512'hA53C, 32'h00, 32'd2, 256'h1C, tbl[0].e, 0, 0, "pre_rst");
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("rst_idle.found", o_found, 1'b0);
    chk("rst_idle.found_nonce", o_fn, 32'h0);
    chk("rst_idle.gold_hash", o_gh, 256'h0);
    chk("rst_idle.hashes_done", o_hd, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    sel = 1'b0; hdr_r = 512'hA53C; base_r = 0; cnt_r = 32'd200; tgt_r = 0; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("rst_run.busy", o_busy, 1'b0);
    chk("rst_run.done", o_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) saw = 1'b1;
    end
    chk("rst_run.no_done", saw, 1'b0);
    run_job(0, 512'hA53C, 32'h00, 32'd2, 256'h20, tbl[1].e, 0, 0, "post_rst");

    for (int j = 0; j < 200; j++) begin
      for (int w = 0; w < 16; w++) rh[w*32 +: 32] = $urandom();
      for (int w = 0; w < 8; w++) rt[w*32 +: 32] = $urandom();
      rt = rt >> $urandom_range(0, 3);
      rb = (j % 4 == 0) ? 32'hFFFF_FFFE : $urandom();
      rc = $urandom_range(0, 9);
      run_job(1, rh, rb, rc, rt, model(1, rh, rb, rc, rt), 0, 0, $sformatf("rand%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
